// File: rtl/ifm_stream_buffer_if.sv
// AXI-Stream beat channel feeding the IFM staging buffer.
// The master drives data/valid and the slave returns ready.
interface ifm_stream_buffer_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/ifm_stream_buffer.sv
// IFM staging buffer: show-ahead FIFO between the IFM stream DMA and the parser.
// Primes the FIFO, pulses start_conv_pulse, then pops one word per parser request.
module ifm_stream_buffer #(
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_conv,
  input  logic [CNT_WIDTH-1:0]  word_count,
  ifm_stream_buffer_if.slave    s_axis,
  input  logic                  input_req,
  output logic [DATA_WIDTH-1:0] fm,
  output logic                  start_conv_pulse,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    PRIME_OCC = (AW+1)'(PRIME_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]    PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [AW:0]            wr_ptr_r, rd_ptr_r;
  logic [AW:0]            occupancy_s;
  logic [CNT_WIDTH-1:0]   total_r, rx_cnt_r, tx_cnt_r;
  logic                   full_s, empty_s;
  logic                   push_s, pop_s, underrun_evt_s, accept_s;
  logic                   prime_ok_s, pulse_s, done_s, tready_s;
  logic                   pulse_r, busy_r, done_r, underrun_r;

  // Occupancy flags from the extra-MSB pointer pair.
  always_comb begin
    occupancy_s = wr_ptr_r - rd_ptr_r;
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  end

  // Stream ready, push/pop qualification and underrun detection.
  always_comb begin
    tready_s       = (state_r != ST_IDLE) && !full_s && (rx_cnt_r < total_r);
    push_s         = s_axis.tvalid && tready_s;
    pop_s          = (state_r == ST_RUN) && input_req && !empty_s;
    underrun_evt_s = (state_r == ST_RUN) && input_req && empty_s;
    prime_ok_s     = (occupancy_s >= PRIME_OCC) || (rx_cnt_r == total_r);
  end

  assign s_axis.tready = tready_s;

  // Show-ahead head: zero whenever nothing is stored.
  always_comb begin
    fm = {DATA_WIDTH{1'b0}};
    if (!empty_s) begin
      fm = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      fm = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state and pulse decode.
  always_comb begin
    state_s  = state_r;
    pulse_s  = 1'b0;
    done_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_conv && (word_count != CNT_ZERO)) begin
          accept_s = 1'b1;
          state_s  = ST_PRIME;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_PRIME: begin
        // The pulse cycle itself is still PRIME; RUN starts one cycle later.
        if (pulse_r) begin
          state_s = ST_RUN;
        end else if (prime_ok_s) begin
          pulse_s = 1'b1;
        end else begin
          state_s = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (pop_s && ((tx_cnt_r + CNT_ONE) == total_r)) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      total_r    <= CNT_ZERO;
      rx_cnt_r   <= CNT_ZERO;
      tx_cnt_r   <= CNT_ZERO;
      pulse_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pulse_r <= pulse_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
      if (accept_s) begin
        total_r    <= word_count;
        rx_cnt_r   <= CNT_ZERO;
        tx_cnt_r   <= CNT_ZERO;
        underrun_r <= 1'b0;
      end else begin
        if (push_s) begin
          rx_cnt_r <= rx_cnt_r + CNT_ONE;
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          tx_cnt_r <= tx_cnt_r + CNT_ONE;
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        if (underrun_evt_s) begin
          underrun_r <= 1'b1;
        end
      end
    end
  end

  // Word storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= s_axis.tdata;
    end
  end

  assign start_conv_pulse = pulse_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign underrun         = underrun_r;

endmodule

// File: doc/ifm_stream_buffer.md
# ifm_stream_buffer

Input-feature-map staging stage between the AXI-Stream IFM DMA port and the IFM parser. Accepts 512-bit stream beats into a small show-ahead FIFO, primes it before a convolution starts, issues the parser's `start_conv_pulse`, and presents the FIFO head on `fm` whenever the parser raises `input_req`, popping one word per requesting cycle. Counts words per convolution and flags underrun.

## Interface
- `DATA_WIDTH`, 512, stream and `fm` word width
- `DEPTH`, 8, FIFO depth in words; power of two, ≥ `PRIME_LEVEL`
- `PRIME_LEVEL`, 5, words buffered before `start_conv_pulse` (matches the parser register count)
- `CNT_WIDTH`, 16, width of word counters
- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — reset, synchronous, active-high
- `start_conv` in 1 — one-cycle request to begin a convolution
- `word_count` in CNT_WIDTH — words in this convolution; sampled when `start_conv` is accepted
- `s_axis_tdata` in DATA_WIDTH — stream data
- `s_axis_tvalid` in 1 — stream valid
- `s_axis_tready` out 1 — stream ready
- `input_req` in 1 — parser consumes `fm` this cycle
- `fm` out DATA_WIDTH — FIFO head, zero when empty
- `start_conv_pulse` out 1 — one-cycle pulse to parser
- `busy` out 1 — high in PRIME and RUN
- `done` out 1 — one-cycle pulse when the last word is popped
- `underrun` out 1 — sticky: `input_req` seen with FIFO empty

## Operation
- FSM states: IDLE, PRIME, RUN.
- IDLE: `start_conv`=1 and `word_count`≠0 → latch `word_count` into `total`, clear `rx_cnt`, `tx_cnt`, `underrun`; go PRIME. `start_conv` with `word_count`=0 is ignored. `start_conv` outside IDLE is ignored.
- Push: `s_axis_tready` = (state≠IDLE) & !full & (`rx_cnt` < `total`). A beat is accepted when `tvalid`&`tready`; `rx_cnt`++.
- PRIME: when occupancy ≥ `PRIME_LEVEL` or `rx_cnt` = `total` (end of register edge), pulse `start_conv_pulse` for exactly one cycle and go RUN next cycle. `input_req` in PRIME is ignored (no pop, no underrun).
- RUN: `input_req`=1 and FIFO non-empty → pop, `tx_cnt`++. `input_req`=1 and FIFO empty → no pop, `underrun` set, `tx_cnt` unchanged.
- Pop that makes `tx_cnt` = `total` → `done` pulses the following cycle, state returns to IDLE. Remaining stream beats are not accepted (`rx_cnt` = `total`).
- Simultaneous push and pop: both take effect; occupancy unchanged. A push into an empty FIFO in the same cycle as `input_req` is an underrun (word not yet visible) and the word is retained.
- Occupancy: pointers of log2(DEPTH)+1 bits; full when MSBs differ and the rest are equal; empty when equal. Wrap at DEPTH.
- `underrun` clears only on `rst` or an accepted `start_conv`.

## Timing
- Reset values: `s_axis_tready`=0, `fm`=0, `start_conv_pulse`=0, `busy`=0, `done`=0, `underrun`=0, state IDLE, pointers and counters 0.
- `fm` is combinational from the registered head: a word written on edge N is visible on `fm` in cycle N+1. `fm` = 0 whenever the FIFO is empty.
- Pop latency 0: with `input_req` high in cycle N, the parser samples `fm` in cycle N; the head advances at the end of cycle N.
- Accepted `start_conv` in cycle N → `busy`=1 and `tready` can rise in cycle N+1.
- PRIME exit condition true in cycle N → `start_conv_pulse`=1 in N+1; RUN from N+2.
- `rst` asserted mid-operation: all state returns to reset values on that edge; FIFO contents are discarded.

## Test plan
- Basic: `word_count`=10, continuous tvalid with data = beat index → `start_conv_pulse` once after the 5th beat is stored; `input_req` held high from then on yields `fm` = 0..9 in order, `done` one cycle after the 10th pop, `underrun`=0.
- Short job: `word_count`=3 → `start_conv_pulse` after the 3rd beat (below PRIME_LEVEL); 3 pops → `done`; a 4th beat offered is never accepted.
- Backpressure: no `input_req`, `word_count`=20 → `tready` drops after 8 accepted beats (full); one pop → `tready` returns next cycle, one more beat accepted.
- Underrun: tvalid stalls after 5 beats, parser requests 6 times → `fm`=0 on the 6th request, `underrun` sets and stays set; remaining beats resume and pop correctly.
- Simultaneous push/pop at occupancy 4 for 10 cycles → occupancy stays 4, order preserved across pointer wrap.
- Reset mid-RUN after 7 of 12 pops → all outputs return to reset values; a new `start_conv` with `word_count`=2 completes normally.
